servo_pwm_decoder: RTL
======================

Name: servo_pwm_decoder

Overview:
- Receive-side counterpart of the servo PWM generator: samples a servo-style PWM line and measures the high time and the frame period, both in clk cycles.
- Validates each frame and decodes the pulse width into an angle of 0..180 degrees.
- Used to loop back and check the generator output, or to accept commands from an external RC/MCU PWM source.
- Sits beside the generator in top and runs from the 24 MHz HSOSC clock.

Parameters:
- CNT_W, 20: width of the cycle counters.
- WIDTH_LO, 12000: minimum legal high time (0.5 ms).
- WIDTH_HI, 60000: maximum legal high time (2.5 ms).
- ANG_ZERO_W, 24000: high time that decodes to 0 deg (1 ms).
- CYC_PER_DEG, 133: cycles per degree above ANG_ZERO_W.
- PERIOD_LO, 432000: minimum legal frame period (18 ms).
- PERIOD_HI, 528000: maximum legal frame period (22 ms).
- TIMEOUT, 960000: edge-free cycles before the signal is declared lost (40 ms).
- FILTER_LEN, 4: stable samples required by the glitch filter (only used when the filter is enabled).

Ports:
- clk  in  1  system clock (24 MHz).
- reset  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM line.
- width_cycles  out  CNT_W  high time of the last valid frame.
- period_cycles  out  CNT_W  period of the last valid frame.
- angle  out  8  decoded angle of the last valid frame, 0..180.
- valid  out  1  one-cycle strobe when the three outputs above update.
- locked  out  1  level; last frame was valid.
- err_width  out  1  one-cycle pulse; high time outside [WIDTH_LO, WIDTH_HI].
- err_period  out  1  one-cycle pulse; period outside [PERIOD_LO, PERIOD_HI].
- lost  out  1  level; TIMEOUT expired.

Interface decision: one clock (clk); reset is asynchronous and active-high.

Behaviour:
- Reset: state IDLE; all outputs and counters 0. Reset mid-frame discards the partial measurement immediately.
- Input path: 2-flop synchronizer, then a registered previous-sample for edge detection.
- A pwm_in transition is seen as rise/fall 3 cycles later.
- FSM states:
  - IDLE: wait for rise, then go to HIGH with pcnt=hcnt=0.
  - HIGH: pcnt and hcnt increment each cycle.
    - On fall: latch hcnt as the frame width and go to LOW.
    - If hcnt reaches WIDTH_HI+1 with no fall: pulse err_width, clear locked, go to IDLE.
  - LOW: pcnt increments.
    - On rise: evaluate the frame, restart pcnt=hcnt=0, stay measuring in HIGH.
    - If pcnt reaches PERIOD_HI+1 with no rise: pulse err_period, clear locked, go to IDLE.
- Frame evaluation (on the rise that ends a frame):
  - Period = pcnt+1.
  - Width < WIDTH_LO: err_width.
  - Else period outside [PERIOD_LO, PERIOD_HI]: err_period.
  - Else: register width_cycles, period_cycles and angle; assert valid for 1 cycle; set locked=1; clear lost.
  - valid asserts on the cycle after the rise is detected, i.e. 4 clk cycles after the pwm_in rising edge.
- Angle decode, sequential with no divider:
  - During HIGH, a sub-counter starts once hcnt >= ANG_ZERO_W.
  - The angle accumulator increments every CYC_PER_DEG cycles and saturates at 180.
  - Width <= ANG_ZERO_W decodes to 0; width >= ANG_ZERO_W+180*CYC_PER_DEG decodes to 180.
  - The accumulator resets at each rise.
- Watchdog:
  - Counts cycles since the last edge of either polarity.
  - Reaching TIMEOUT sets lost=1, clears locked, forces IDLE.
  - lost holds until the next valid frame.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- Error pulses are single-cycle. err_width and err_period are never asserted together.
- The first rise after IDLE starts a frame but never produces valid.
- Counters saturate at all-ones and never wrap; TIMEOUT < 2^CNT_W.

Optional Feature:
- Macro: SERVO_PWM_DECODER_GLITCH_FILTER_EN.
- Defined: the synchronized input passes through a filter. The filtered level changes only after FILTER_LEN consecutive identical samples.
  - Edge latency grows by FILTER_LEN cycles, so valid comes 4+FILTER_LEN cycles after the rise.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - Measured width and period are unchanged for clean input, because both edges are delayed equally.
- Undefined: no filter; every synchronized transition counts as an edge.

Decomposition:
- Shared package servo_pkg holds:
  - the decoder state enum (IDLE, HIGH, LOW);
  - CLK_HZ=24_000_000 and FRAME_CYCLES=480000;
  - the generator pulse constants 2400, 3600 and 26400;
  - the angle codes 0, 20 and 90, shared with pwmgen and angledecoder.
- One sub-module, pwm_edge_detect: synchronizer, optional glitch filter, and the registered rise/fall strobes.

Test Plan:
- Clean frames, 36000 high / 480000 period, repeated 3 times: no valid on the first rise; then valid with width_cycles=36000, period_cycles=480000, angle=90; locked=1.
- Width 24000 gives angle=0. Width 48000 gives angle=180, saturating from a raw count of 180.45.
- Width 8000 at period 480000: err_width pulse at the frame rise, no valid, locked=0. Width 70000: err_width when hcnt reaches 60001, then IDLE.
- Period 400000 with width 36000: err_period at the rise, outputs keep their previous values. A line held low after the fall: err_period when pcnt reaches 528001.
- Line stuck high for 1,000,000 cycles: err_width first, then lost=1 at 960000 cycles after the rise. The next two clean frames give valid and clear lost.
- Reset asserted mid-HIGH: all outputs 0 asynchronously, first post-reset frame produces no valid. Glitch build: a 2-cycle low glitch inside the high time is ignored and width is unchanged.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo definitions: decoder FSM states, clock/frame constants, generator pulse and angle codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dec_state_e;

    localparam int unsigned CLK_HZ       = 24_000_000;
    localparam int unsigned FRAME_CYCLES = 480000;

    // Pulse lengths used by the PWM generator beside this decoder.
    localparam int unsigned GEN_PULSE_SHORT = 2400;
    localparam int unsigned GEN_PULSE_MID   = 3600;
    localparam int unsigned GEN_PULSE_LONG  = 26400;

    // Angle codes shared with pwmgen and angledecoder.
    localparam logic [7:0] ANGLE_CODE_0  = 8'd0;
    localparam logic [7:0] ANGLE_CODE_20 = 8'd20;
    localparam logic [7:0] ANGLE_CODE_90 = 8'd90;
    localparam logic [7:0] ANGLE_MAX     = 8'd180;

    // Degree accumulator step that sticks at the top of the servo range.
    function automatic logic [7:0] angle_inc(input logic [7:0] a);
        return (a >= ANGLE_MAX) ? ANGLE_MAX : a + 8'd1;
    endfunction

endpackage

// File: rtl/pwm_edge_detect.sv
// Synchronizes the raw PWM line, optionally debounces it, and emits registered rise/fall strobes.
// Latency: strobe 3 cycles after a pwm_in edge (+FILTER_LEN with SERVO_PWM_DECODER_GLITCH_FILTER_EN).
// Backpressure: none; free-running sampler, strobes are single-cycle.
module pwm_edge_detect #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Two-flop synchronizer for the asynchronous line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SERVO_PWM_DECODER_GLITCH_FILTER_EN
    localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Follow the synchronized level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Edge decode against the previous sample of the (filtered) level.
    always_comb begin
        rise_d = level & ~prev_q;
        fall_d = ~level & prev_q;
    end

    // Previous-sample register and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= level;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo PWM high time and frame period, validates each frame and decodes the width to 0..180 deg.
// Latency: valid 4 cycles after the frame-ending pwm_in rise (4+FILTER_LEN with SERVO_PWM_DECODER_GLITCH_FILTER_EN).
// Backpressure: none; outputs are strobes/levels, a consumer that misses valid keeps the held outputs.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned WIDTH_LO    = 12000,
    parameter int unsigned WIDTH_HI    = 60000,
    parameter int unsigned ANG_ZERO_W  = 24000,
    parameter int unsigned CYC_PER_DEG = 133,
    parameter int unsigned PERIOD_LO   = 432000,
    parameter int unsigned PERIOD_HI   = 528000,
    parameter int unsigned TIMEOUT     = 960000,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width_cycles,
    output logic [CNT_W-1:0] period_cycles,
    output logic [7:0]       angle,
    output logic             valid,
    output logic             locked,
    output logic             err_width,
    output logic             err_period,
    lost
);

    localparam logic [CNT_W-1:0] W_LO    = CNT_W'(WIDTH_LO);
    localparam logic [CNT_W-1:0] W_HI    = CNT_W'(WIDTH_HI);
    localparam logic [CNT_W-1:0] W_TMO   = CNT_W'(WIDTH_HI + 1);
    localparam logic [CNT_W-1:0] P_LO    = CNT_W'(PERIOD_LO);
    localparam logic [CNT_W-1:0] P_HI    = CNT_W'(PERIOD_HI);
    localparam logic [CNT_W-1:0] P_TMO   = CNT_W'(PERIOD_HI + 1);
    localparam logic [CNT_W-1:0] ANG_ST  = CNT_W'(ANG_ZERO_W);
    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(CYC_PER_DEG - 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic rise, fall;

    pwm_edge_detect #(
        .FILTER_LEN(FILTER_LEN)
    ) u_edge (
        .clk   (clk),
        .rst   (reset),
        .pwm_in(pwm_in),
        .rise  (rise),
        .fall  (fall)
    );

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;      // cycles since the frame-starting rise
    logic [CNT_W-1:0] hcnt_q, hcnt_d;      // cycles in the high phase
    logic [CNT_W-1:0] sc_q, sc_d;          // cycles within the current degree
    logic [7:0]       acc_q, acc_d;        // degrees accumulated this frame
    logic [CNT_W-1:0] fw_q, fw_d;          // width of the frame being measured
    logic [CNT_W-1:0] wd_q, wd_d;          // cycles since the last edge
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       angle_q, angle_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             err_width_q, err_width_d;
    logic             err_period_q, err_period_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] frame_period;
    logic             any_edge;

    // Frame measurement FSM, angle accumulation, validation and watchdog.
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        hcnt_d       = hcnt_q;
        sc_d         = sc_q;
        acc_d        = acc_q;
        fw_d         = fw_q;
        width_d      = width_q;
        period_d     = period_q;
        angle_d      = angle_q;
        valid_d      = 1'b0;
        err_width_d  = 1'b0;
        err_period_d = 1'b0;
        locked_d     = locked_q;
        lost_d       = lost_q;
        any_edge     = rise | fall;
        wd_d         = any_edge ? '0 : sat_inc(wd_q);
        frame_period = sat_inc(pcnt_q);

        case (state_q)
            IDLE: begin
                // A rise out of IDLE only opens a frame; nothing to evaluate yet.
                if (rise) begin
                    state_d = HIGH;
                    pcnt_d  = '0;
                    hcnt_d  = '0;
                    sc_d    = '0;
                    acc_d   = '0;
                end
            end
            HIGH: begin
                pcnt_d = sat_inc(pcnt_q);
                hcnt_d = sat_inc(hcnt_q);
                // hcnt_d is the high time so far; degrees start past ANG_ZERO_W.
                if (hcnt_d > ANG_ST) begin
                    if (sc_q == SC_LAST) begin
                        sc_d  = '0;
                        acc_d = angle_inc(acc_q);
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
                if (fall) begin
                    fw_d    = hcnt_d;
                    state_d = LOW;
                end else if (hcnt_q == W_TMO) begin
                    err_width_d = 1'b1;
                    locked_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            LOW: begin
                pcnt_d = sat_inc(pcnt_q);
                if (rise) begin
                    if (fw_q < W_LO || fw_q > W_HI) begin
                        err_width_d = 1'b1;
                        locked_d    = 1'b0;
                    end else if (frame_period < P_LO || frame_period > P_HI) begin
                        err_period_d = 1'b1;
                        locked_d     = 1'b0;
                    end else begin
                        width_d  = fw_q;
                        period_d = frame_period;
                        angle_d  = acc_q;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                        lost_d   = 1'b0;
                    end
                    // This rise also opens the next frame.
                    state_d = HIGH;
                    pcnt_d  = '0;
                    hcnt_d  = '0;
                    sc_d    = '0;
                    acc_d   = '0;
                end else if (pcnt_q == P_TMO) begin
                    err_period_d = 1'b1;
                    locked_d     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog expiry; an edge in the same cycle keeps the signal alive.
        if (!any_edge && wd_q == WD_LAST) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            state_d  = IDLE;
        end
    end

    // State, counter and output registers; reset drops any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            hcnt_q       <= '0;
            sc_q         <= '0;
            acc_q        <= '0;
            fw_q         <= '0;
            wd_q         <= '0;
            width_q      <= '0;
            period_q     <= '0;
            angle_q      <= '0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            err_width_q  <= 1'b0;
            err_period_q <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            hcnt_q       <= hcnt_d;
            sc_q         <= sc_d;
            acc_q        <= acc_d;
            fw_q         <= fw_d;
            wd_q         <= wd_d;
            width_q      <= width_d;
            period_q     <= period_d;
            angle_q      <= angle_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            err_width_q  <= err_width_d;
            err_period_q <= err_period_d;
            lost_q       <= lost_d;
        end
    end

    assign width_cycles  = width_q;
    assign period_cycles = period_q;
    assign angle         = angle_q;
    assign valid         = valid_q;
    assign locked        = locked_q;
    assign err_width     = err_width_q;
    assign err_period    = err_period_q;
    assign lost          = lost_q;

endmodule
